// File: rtl/vdc_dispfetch.sv
// vdc_dispfetch: per-row screen/attribute/font fetcher feeding a line buffer; define VDC_ATTR_EN to build the attribute fetch
module vdc_dispfetch (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_enable,
  input  logic        i_start,
  input  logic [7:0]  i_cols,
  input  logic [15:0] i_disp_addr,
  input  logic [15:0] i_attr_addr,
  input  logic        i_attr_en,
  input  logic [15:0] i_char_base,
  input  logic        i_char32,
  input  logic [4:0]  i_row_line,
  output logic        o_ram_req,
  input  logic        i_ram_gnt,
  output logic [15:0] o_ram_addr,
  input  logic [7:0]  i_ram_do,
  output logic        o_buf_we,
  output logic [7:0]  o_buf_idx,
  output logic [7:0]  o_buf_char,
  output logic [7:0]  o_buf_attr,
  output logic        o_busy,
  output logic        o_done
);
  typedef enum logic [2:0] {
    S_IDLE, S_SCR_I, S_SCR_C, S_ATR_I, S_ATR_C, S_FNT_I, S_FNT_C, S_DONE
  } state_t;
  state_t      r_state;
  logic [7:0]  r_cols, r_i, r_code, r_attr;
  logic [15:0] r_disp, r_base;
  logic        r_char32;
  logic [4:0]  r_row;
  logic        r_ram_req, r_buf_we, r_busy, r_done;
  logic [15:0] r_ram_addr;
  logic [7:0]  r_buf_idx, r_buf_char, r_buf_attr;
  logic        w_last;
  logic [15:0] w_next_scr;
`ifdef VDC_ATTR_EN
  logic [15:0] r_abase;
  logic        r_attr_en;
`else
  logic        w_unused_attr;
  assign w_unused_attr = ^{i_attr_en, i_attr_addr};
`endif
  assign w_last     = (r_i == r_cols - 8'd1);
  assign w_next_scr = r_disp + {8'd0, r_i} + 16'd1;
  assign o_ram_req  = r_ram_req;
  assign o_ram_addr = r_ram_addr;
  assign o_buf_we   = r_buf_we;
  assign o_buf_idx  = r_buf_idx;
  assign o_buf_char = r_buf_char;
  assign o_buf_attr = r_buf_attr;
  assign o_busy     = r_busy;
  assign o_done     = r_done;
  // Glyph row address: 16-byte glyphs use row_line[3:0], 32-byte glyphs use row_line[4:0]
  function automatic logic [15:0] f_font(input logic [7:0] code, input logic alt);
    return r_char32 ? {r_base[15:14], alt, code, r_row} : {r_base[15:13], alt, code, r_row[3:0]};
  endfunction
  // Fetch sequencer: each read has an issue phase (held until grant) and a capture phase
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state    <= S_IDLE;
      r_cols     <= '0;
      r_i        <= '0;
      r_code     <= '0;
      r_attr     <= '0;
      r_disp     <= '0;
      r_base     <= '0;
      r_char32   <= 1'b0;
      r_row      <= '0;
      r_ram_req  <= 1'b0;
      r_ram_addr <= '0;
      r_buf_we   <= 1'b0;
      r_buf_idx  <= '0;
      r_buf_char <= '0;
      r_buf_attr <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
`ifdef VDC_ATTR_EN
      r_abase    <= '0;
      r_attr_en  <= 1'b0;
`endif
    end else if (i_enable) begin
      r_buf_we <= 1'b0;
      r_done   <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_start && i_cols != 8'd0) begin
            r_cols     <= i_cols;
            r_disp     <= i_disp_addr;
            r_base     <= i_char_base;
            r_char32   <= i_char32;
            r_row      <= i_row_line;
            r_i        <= '0;
            r_attr     <= '0;
            r_busy     <= 1'b1;
            r_ram_req  <= 1'b1;
            r_ram_addr <= i_disp_addr;
            r_state    <= S_SCR_I;
`ifdef VDC_ATTR_EN
            r_abase    <= i_attr_addr;
            r_attr_en  <= i_attr_en;
`endif
          end else if (i_start) begin
            r_state <= S_DONE;
          end
        end
        S_SCR_I: begin
          if (i_ram_gnt) begin
            r_ram_req <= 1'b0;
            r_state   <= S_SCR_C;
          end
        end
        S_SCR_C: begin
          r_code    <= i_ram_do;
          r_ram_req <= 1'b1;
`ifdef VDC_ATTR_EN
          if (r_attr_en) begin
            r_ram_addr <= r_abase + {8'd0, r_i};
            r_state    <= S_ATR_I;
          end else
`endif
          begin
            r_ram_addr <= f_font(i_ram_do, 1'b0);
            r_state    <= S_FNT_I;
          end
        end
`ifdef VDC_ATTR_EN
        S_ATR_I: begin
          if (i_ram_gnt) begin
            r_ram_req <= 1'b0;
            r_state   <= S_ATR_C;
          end
        end
        S_ATR_C: begin
          r_attr     <= i_ram_do;
          r_ram_req  <= 1'b1;
          r_ram_addr <= f_font(r_code, i_ram_do[7]);
          r_state    <= S_FNT_I;
        end
`endif
        S_FNT_I: begin
          if (i_ram_gnt) begin
            r_ram_req <= 1'b0;
            r_state   <= S_FNT_C;
          end
        end
        S_FNT_C: begin
          r_buf_we   <= 1'b1;
          r_buf_idx  <= r_i;
          r_buf_char <= i_ram_do;
          r_buf_attr <= r_attr;
          r_i        <= r_i + 8'd1;
          if (w_last) begin
            r_state <= S_DONE;
          end else begin
            r_ram_req  <= 1'b1;
            r_ram_addr <= w_next_scr;
            r_state    <= S_SCR_I;
          end
        end
        S_DONE: begin
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_vdc_dispfetch.sv
// tb_vdc_dispfetch: randomized bench for vdc_dispfetch with a RAM model and a read/write trace reference
module tb_vdc_dispfetch;
`ifdef VDC_ATTR_EN
  localparam bit HAS_ATTR = 1'b1;
`else
  localparam bit HAS_ATTR = 1'b0;
`endif
  logic        clk = 1'b0, reset_n = 1'b0, enable = 1'b1, start = 1'b0;
  logic [7:0]  cols = '0;
  logic [15:0] disp_addr = '0, attr_addr = '0, char_base = '0;
  logic        attr_en = 1'b0, char32 = 1'b0;
  logic [4:0]  row_line = '0;
  logic        ram_req, ram_gnt = 1'b1;
  logic [15:0] ram_addr;
  logic [7:0]  ram_do = '0;
  logic        buf_we, busy, done;
  logic [7:0]  buf_idx, buf_char, buf_attr;
  logic [7:0]  mem [0:65535];
  int          n_vec = 0, n_bad = 0, cyc = 0, gnt_hold = 0, stall_we = 0;
  int          done_cnt = 0, done_cyc = 0;
  bit          en_rand = 0, gnt_rand = 0, prev_pend = 0;
  logic [15:0] prev_addr = '0;
  logic [15:0] rd_q[$], exp_rd[$];
  logic [23:0] wr_q[$], exp_wr[$];

  vdc_dispfetch dut (
    .i_clk(clk), .i_reset_n(reset_n), .i_enable(enable), .i_start(start),
    .i_cols(cols), .i_disp_addr(disp_addr), .i_attr_addr(attr_addr), .i_attr_en(attr_en),
    .i_char_base(char_base), .i_char32(char32), .i_row_line(row_line),
    .o_ram_req(ram_req), .i_ram_gnt(ram_gnt), .o_ram_addr(ram_addr), .i_ram_do(ram_do),
    .o_buf_we(buf_we), .o_buf_idx(buf_idx), .o_buf_char(buf_char), .o_buf_attr(buf_attr),
    .o_busy(busy), .o_done(done)
  );

  always #5 clk = ~clk;

  // RAM: data of an issued read is presented from the next cycle on
  always @(posedge clk) if (enable && ram_req && ram_gnt) ram_do <= mem[ram_addr];

  // Drive enable/grant for the coming edge and record what that edge will see
  always @(negedge clk) begin
    cyc++;
    enable = en_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
    if (gnt_hold > 0 && ram_req) begin
      ram_gnt = 1'b0;
      gnt_hold--;
      if (buf_we) stall_we++;
    end else ram_gnt = gnt_rand ? ($urandom_range(0, 2) != 0) : 1'b1;
    if (reset_n) begin
      if (ram_req && prev_pend) begin
        n_vec++;
        if (ram_addr !== prev_addr) begin
          n_bad++;
          $display("FAIL addr_stable: ram_addr=%h required %h", ram_addr, prev_addr);
        end
      end
      prev_pend = ram_req && !(enable && ram_gnt);
      prev_addr = ram_addr;
      if (enable && ram_req && ram_gnt) rd_q.push_back(ram_addr);
      if (enable && buf_we) wr_q.push_back({buf_idx, buf_char, buf_attr});
      if (enable && done) begin
        done_cnt++;
        done_cyc = cyc - 1;
      end
    end else prev_pend = 0;
  end

  // Reference: expected RAM read sequence and line-buffer writes for one row
  task automatic build_expect(input logic [7:0] c, input logic [15:0] d, aa, input logic ae,
                              input logic [15:0] b, input logic c32, input logic [4:0] row);
    logic [7:0] code, at;
    logic [15:0] fa;
    bit on;
    on = HAS_ATTR && ae;
    exp_rd.delete();
    exp_wr.delete();
    for (int i = 0; i < c; i++) begin
      code = mem[d + 16'(i)];
      at = on ? mem[aa + 16'(i)] : 8'h00;
      fa = c32 ? {b[15:14], at[7], code, row} : {b[15:13], at[7], code, row[3:0]};
      exp_rd.push_back(d + 16'(i));
      if (on) exp_rd.push_back(aa + 16'(i));
      exp_rd.push_back(fa);
      exp_wr.push_back({8'(i), mem[fa], at});
    end
  endtask

  task automatic do_start(input logic [7:0] c, input logic [15:0] d, aa, input logic ae,
                          input logic [15:0] b, input logic c32, input logic [4:0] row,
                          input bit junk, output int acc);
    int k;
    @(negedge clk);
    cols = c; disp_addr = d; attr_addr = aa; attr_en = ae; char_base = b; char32 = c32; row_line = row;
    start = 1'b1;
    for (k = 0; k < 200; k++) begin
      @(posedge clk);
      if (enable) break;
    end
    acc = cyc;
    n_vec++;
    if (k == 200) begin
      n_bad++;
      $display("FAIL start_accept: no enabled edge in %0d cycles, required one", k);
    end
    @(negedge clk);
    if (junk) begin
      cols = 8'($urandom); disp_addr = 16'($urandom); attr_addr = 16'($urandom);
      attr_en = 1'($urandom); char_base = 16'($urandom); char32 = 1'($urandom); row_line = 5'($urandom);
      @(negedge clk);
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  task automatic run_fetch(input string nm, input logic [7:0] c, input logic [15:0] d, aa, input logic ae,
                           input logic [15:0] b, input logic c32, input logic [4:0] row,
                           input bit chk_lat, input bit junk);
    int acc, k, lat;
    rd_q.delete();
    wr_q.delete();
    done_cnt = 0;
    build_expect(c, d, aa, ae, b, c32, row);
    do_start(c, d, aa, ae, b, c32, row, junk && c != 0, acc);
    if (c != 0) begin
      n_vec++;
      if (busy !== 1'b1) begin
        n_bad++;
        $display("FAIL %s busy_run: busy=%b required 1", nm, busy);
      end
    end
    for (k = 0; k < 5000; k++) begin
      if (done_cnt > 0) break;
      @(negedge clk);
    end
    repeat (3) @(negedge clk);
    n_vec++;
    if (done_cnt != 1) begin
      n_bad++;
      $display("FAIL %s done_count: got %0d done pulses, required 1", nm, done_cnt);
    end
    if (chk_lat) begin
      lat = int'(c) * ((HAS_ATTR && ae) ? 6 : 4) + 1;
      n_vec++;
      if (done_cyc - acc != lat) begin
        n_bad++;
        $display("FAIL %s latency: done %0d cycles after start, required %0d", nm, done_cyc - acc, lat);
      end
    end
    n_vec++;
    if (busy !== 1'b0) begin
      n_bad++;
      $display("FAIL %s busy_end: busy=%b required 0", nm, busy);
    end
    n_vec++;
    if (rd_q.size() != exp_rd.size()) begin
      n_bad++;
      $display("FAIL %s read_count: %0d reads, required %0d", nm, rd_q.size(), exp_rd.size());
    end
    for (int i = 0; i < rd_q.size() && i < exp_rd.size(); i++) begin
      n_vec++;
      if (rd_q[i] !== exp_rd[i]) begin
        n_bad++;
        $display("FAIL %s read[%0d]: addr=%h required %h", nm, i, rd_q[i], exp_rd[i]);
      end
    end
    n_vec++;
    if (wr_q.size() != exp_wr.size()) begin
      n_bad++;
      $display("FAIL %s write_count: %0d writes, required %0d", nm, wr_q.size(), exp_wr.size());
    end
    for (int i = 0; i < wr_q.size() && i < exp_wr.size(); i++) begin
      n_vec++;
      if (wr_q[i] !== exp_wr[i]) begin
        n_bad++;
        $display("FAIL %s write[%0d]: idx/char/attr=%h required %h", nm, i, wr_q[i], exp_wr[i]);
      end
    end
  endtask

  task automatic check_idle_outputs(input string nm);
    n_vec++;
    if ({ram_req, buf_we, busy, done, ram_addr, buf_idx, buf_char, buf_attr} !== 44'd0) begin
      n_bad++;
      $display("FAIL %s: req=%b we=%b busy=%b done=%b addr=%h idx=%h char=%h attr=%h required all 0",
               nm, ram_req, buf_we, busy, done, ram_addr, buf_idx, buf_char, buf_attr);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    check_idle_outputs("reset_outputs");
    reset_n = 1'b1;
    rd_q.delete();
    repeat (4) @(negedge clk);
    check_idle_outputs("post_reset_idle");
    n_vec++;
    if (rd_q.size() != 0) begin
      n_bad++;
      $display("FAIL post_reset_reads: %0d reads, required 0", rd_q.size());
    end
  endtask

  task automatic test_basic();
    logic [15:0] want [3];
    want = '{16'h2412, 16'h2422, 16'h2432};
    mem[0] = 8'h41; mem[1] = 8'h42; mem[2] = 8'h43;
    run_fetch("basic", 8'd3, 16'h0000, 16'h0000, 1'b0, 16'h2000, 1'b0, 5'd2, 1, 0);
    for (int j = 0; j < 3; j++) begin
      n_vec++;
      if (rd_q.size() < 6 || rd_q[2*j+1] !== want[j]) begin
        n_bad++;
        $display("FAIL basic_font_addr[%0d]: addr=%h required %h", j, rd_q.size() < 6 ? 16'hxxxx : rd_q[2*j+1], want[j]);
      end
    end
  endtask

  task automatic test_attr();
    logic [7:0] want_attr;
    want_attr = HAS_ATTR ? 8'h80 : 8'h00;
    mem[16'h0100] = 8'h01;
    mem[16'h0800] = 8'h80;
    run_fetch("attr", 8'd1, 16'h0100, 16'h0800, 1'b1, 16'h2000, 1'b1, 5'd5, 1, 0);
    n_vec++;
    if (wr_q.size() < 1 || wr_q[0][7:0] !== want_attr) begin
      n_bad++;
      $display("FAIL attr_byte: buf_attr=%h required %h", wr_q.size() < 1 ? 8'hxx : wr_q[0][7:0], want_attr);
    end
  endtask

  task automatic test_wrap();
    run_fetch("wrap", 8'd2, 16'hFFFF, 16'h1234, 1'b0, 16'h4000, 1'b0, 5'd7, 1, 0);
    n_vec++;
    if (rd_q.size() < 3 || rd_q[0] !== 16'hFFFF || rd_q[2] !== 16'h0000) begin
      n_bad++;
      $display("FAIL wrap_screen: reads %h,%h required ffff,0000",
               rd_q.size() > 0 ? rd_q[0] : 16'hxxxx, rd_q.size() > 2 ? rd_q[2] : 16'hxxxx);
    end
  endtask

  task automatic test_stall();
    stall_we = 0;
    gnt_hold = 5;
    run_fetch("stall", 8'd2, 16'h0300, 16'h0900, 1'b1, 16'hA000, 1'b0, 5'd9, 0, 0);
    n_vec++;
    if (gnt_hold != 0 || stall_we != 0) begin
      n_bad++;
      $display("FAIL stall: hold_left=%0d buf_we_during_stall=%0d required 0/0", gnt_hold, stall_we);
    end
  endtask

  task automatic test_reset_mid();
    int acc;
    do_start(8'd8, 16'h0500, 16'h0A00, 1'b1, 16'h6000, 1'b1, 5'd17, 0, acc);
    repeat (6) @(negedge clk);
    #2 reset_n = 1'b0;
    #1 check_idle_outputs("mid_reset_outputs");
    @(negedge clk);
    reset_n = 1'b1;
    rd_q.delete();
    repeat (10) @(negedge clk);
    n_vec++;
    if (rd_q.size() != 0 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL mid_reset_quiet: %0d reads busy=%b required 0 reads busy=0", rd_q.size(), busy);
    end
    run_fetch("zero_cols", 8'd0, 16'h0000, 16'h0000, 1'b1, 16'h0000, 1'b0, 5'd0, 0, 0);
  endtask

  task automatic test_random();
    logic [15:0] d;
    en_rand = 1;
    gnt_rand = 1;
    for (int t = 0; t < 20; t++) begin
      d = ($urandom_range(0, 3) == 0) ? 16'hFFF8 + 16'($urandom_range(0, 7)) : 16'($urandom);
      run_fetch("random", 8'($urandom_range(1, 10)), d, 16'($urandom), 1'($urandom),
                16'($urandom), 1'($urandom), 5'($urandom), 0, 1);
    end
    en_rand = 0;
    gnt_rand = 0;
  endtask

  initial begin
    for (int a = 0; a < 65536; a++) mem[a] = 8'($urandom);
    test_reset();
    test_basic();
    test_attr();
    test_wrap();
    test_stall();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
